// File: rtl/conv1_sched.sv
// Conv1 layer sequencer: loads four biases, then streams 32-tap stride-8 windows over
// every input sequence, handing each window to Conv1 and waiting for its conv_end.
module conv1_sched #(
    parameter int unsigned KERNEL      = 32,
    parameter int unsigned STRIDE      = 8,
    parameter int unsigned WIN_PER_SEQ = 61,
    parameter int unsigned SEQ_NUM     = 42,
    parameter int unsigned DRAIN_MAX   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       seq_ready,
    input  logic       conv_end,
    output logic       b_rd,
    output logic [1:0] b_addr,
    output logic       c1_b_en,
    output logic       w_rd,
    output logic [4:0] w_addr,
    output logic       c1_w_en,
    output logic       d_rd,
    output logic [8:0] d_addr,
    output logic       valid,
    output logic [5:0] win_idx,
    output logic [5:0] seq_idx,
    output logic       seq_done,
    output logic       layer_done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {StIdle, StBias, StWaitSeq, StStream, StDrain, StNext} state_e;

    localparam logic [6:0] BiasLast  = 7'd3;
    localparam logic [6:0] TapLast   = 7'(KERNEL - 1);
    localparam logic [6:0] DrainLast = 7'(DRAIN_MAX - 1);
    localparam logic [5:0] WinLast   = 6'(WIN_PER_SEQ - 1);
    localparam logic [5:0] SeqLast   = 6'(SEQ_NUM - 1);

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [5:0] win_q, win_d;
    logic [5:0] seq_q, seq_d;
    logic       err_q, err_d;
    logic       seq_done_q, seq_done_d;
    logic       layer_done_q, layer_done_d;
    logic       c1_b_en_q, c1_w_en_q, valid_q;
    logic [8:0] win_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            win_q        <= '0;
            seq_q        <= '0;
            err_q        <= 1'b0;
            seq_done_q   <= 1'b0;
            layer_done_q <= 1'b0;
            c1_b_en_q    <= 1'b0;
            c1_w_en_q    <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            seq_q        <= seq_d;
            err_q        <= err_d;
            seq_done_q   <= seq_done_d;
            layer_done_q <= layer_done_d;
            c1_b_en_q    <= b_rd;
            c1_w_en_q    <= w_rd;
            valid_q      <= d_rd;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        seq_d        = seq_q;
        err_d        = err_q;
        seq_done_d   = 1'b0;
        layer_done_d = 1'b0;

        // A window-complete pulse is only meaningful while draining.
        if (conv_end && state_q != StDrain) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBias;
                    cnt_d   = '0;
                    win_d   = '0;
                    seq_d   = '0;
                    err_d   = conv_end;
                end
            end
            StBias: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == BiasLast) begin
                    state_d = StWaitSeq;
                    cnt_d   = '0;
                end
            end
            StWaitSeq: begin
                if (seq_ready) begin
                    state_d = StStream;
                    cnt_d   = '0;
                end
            end
            StStream: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == TapLast) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                // conv_end wins over a timeout landing in the same cycle.
                cnt_d = cnt_q + 7'd1;
                if (conv_end) begin
                    state_d = StNext;
                    cnt_d   = '0;
                end else if (cnt_q == DrainLast) begin
                    state_d = StNext;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            StNext: begin
                cnt_d = '0;
                if (win_q < WinLast) begin
                    win_d   = win_q + 6'd1;
                    state_d = StStream;
                end else begin
                    win_d      = '0;
                    seq_done_d = 1'b1;
                    if (seq_q < SeqLast) begin
                        seq_d   = seq_q + 6'd1;
                        state_d = StWaitSeq;
                    end else begin
                        seq_d        = '0;
                        layer_done_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign win_ext = {3'b000, win_q};

    assign b_rd       = (state_q == StBias);
    assign b_addr     = b_rd ? cnt_q[1:0] : 2'd0;
    assign w_rd       = (state_q == StStream);
    assign d_rd       = (state_q == StStream);
    assign w_addr     = w_rd ? cnt_q[4:0] : 5'd0;
    assign d_addr     = d_rd ? (win_ext * 9'(STRIDE) + {4'b0000, cnt_q[4:0]}) : 9'd0;
    assign c1_b_en    = c1_b_en_q;
    assign c1_w_en    = c1_w_en_q;
    assign valid      = valid_q;
    assign win_idx    = win_q;
    assign seq_idx    = seq_q;
    assign seq_done   = seq_done_q;
    assign layer_done = layer_done_q;
    assign busy       = (state_q != StIdle);
    assign err        = err_q;

endmodule

// File: tb/tb_conv1_sched.sv
// Bench for conv1_sched: a negedge monitor predicts every tap address into a queue at window
// start and pops it per read; scenario tasks check bias load, timing, errors and a full layer.
module tb_conv1_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic       seq_ready;
    logic       conv_end;
    logic       ce_auto;
    logic       ce_stray;
    logic       b_rd;
    logic [1:0] b_addr;
    logic       c1_b_en;
    logic       w_rd;
    logic [4:0] w_addr;
    logic       c1_w_en;
    logic       d_rd;
    logic [8:0] d_addr;
    logic       valid;
    logic [5:0] win_idx;
    logic [5:0] seq_idx;
    logic       seq_done;
    logic       layer_done;
    logic       busy;
    logic       err;

    logic [37:0] all_out;
    logic        d_rd_prev, w_rd_prev, b_rd_prev;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ce_delay = 3;
    bit          ce_withhold = 1'b0;
    int          m_win, m_seq;
    logic [13:0] exp_q[$];

    conv1_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seq_ready  (seq_ready),
        .conv_end   (conv_end),
        .b_rd       (b_rd),
        .b_addr     (b_addr),
        .c1_b_en    (c1_b_en),
        .w_rd       (w_rd),
        .w_addr     (w_addr),
        .c1_w_en    (c1_w_en),
        .d_rd       (d_rd),
        .d_addr     (d_addr),
        .valid      (valid),
        .win_idx    (win_idx),
        .seq_idx    (seq_idx),
        .seq_done   (seq_done),
        .layer_done (layer_done),
        .busy       (busy),
        .err        (err)
    );

    assign conv_end = ce_auto | ce_stray;
    assign all_out  = {b_rd, b_addr, c1_b_en, w_rd, w_addr, c1_w_en, d_rd, d_addr, valid,
                       win_idx, seq_idx, seq_done, layer_done, busy, err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rd_prev <= 1'b0;
            w_rd_prev <= 1'b0;
            b_rd_prev <= 1'b0;
        end else begin
            d_rd_prev <= d_rd;
            w_rd_prev <= w_rd;
            b_rd_prev <= b_rd;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: predict a window's 32 (w_addr, d_addr) pairs when its stream starts.
    initial begin
        logic [13:0] e;
        m_win = 0;
        m_seq = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_win = 0;
                m_seq = 0;
                exp_q.delete();
            end else begin
                if (start && !busy) begin
                    m_win = 0;
                    m_seq = 0;
                    exp_q.delete();
                end
                n_checks++;
                if (valid !== d_rd_prev) begin
                    n_fail++;
                    $display("FAIL valid_lag: valid=%b required=%b", valid, d_rd_prev);
                end
                n_checks++;
                if (c1_w_en !== w_rd_prev) begin
                    n_fail++;
                    $display("FAIL w_en_lag: c1_w_en=%b required=%b", c1_w_en, w_rd_prev);
                end
                n_checks++;
                if (c1_b_en !== b_rd_prev) begin
                    n_fail++;
                    $display("FAIL b_en_lag: c1_b_en=%b required=%b", c1_b_en, b_rd_prev);
                end
                if (d_rd && !d_rd_prev) begin
                    n_checks++;
                    if (exp_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL win_leftover: %0d taps pending, required 0", exp_q.size());
                    end
                    exp_q.delete();
                    for (int t = 0; t < 32; t++) exp_q.push_back({5'(t), 9'(m_win * 8 + t)});
                end
                if (d_rd) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_tap: d_addr=%0d with no tap expected", d_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (d_addr !== e[8:0] || w_addr !== e[13:9] || w_rd !== 1'b1 ||
                            win_idx !== 6'(m_win) || seq_idx !== 6'(m_seq)) begin
                            n_fail++;
                            $display("FAIL tap: d_addr=%0d w_addr=%0d w_rd=%b win=%0d seq=%0d required d_addr=%0d w_addr=%0d w_rd=1 win=%0d seq=%0d",
                                     d_addr, w_addr, w_rd, win_idx, seq_idx, e[8:0], e[13:9],
                                     m_win, m_seq);
                        end
                    end
                end
                if (!d_rd && d_rd_prev) begin
                    n_checks++;
                    if (exp_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL missing_taps: %0d taps not read, required 0", exp_q.size());
                    end
                    if (m_win == 60) begin
                        m_win = 0;
                        m_seq = (m_seq == 41) ? 0 : m_seq + 1;
                    end else begin
                        m_win++;
                    end
                end
            end
        end
    end

    // Conv1 stand-in: conv_end ce_delay cycles into DRAIN unless withheld.
    initial begin
        int r_cnt;
        r_cnt   = 0;
        ce_auto = 1'b0;
        forever begin
            @(negedge clk);
            ce_auto = 1'b0;
            if (rst) begin
                r_cnt = 0;
            end else begin
                if (!d_rd && d_rd_prev && !ce_withhold) r_cnt = ce_delay;
                if (r_cnt > 0) begin
                    r_cnt--;
                    if (r_cnt == 0) ce_auto = 1'b1;
                end
            end
        end
    end

    task automatic wait_edge(input bit want_rise, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (want_rise ? (d_rd && !d_rd_prev) : (!d_rd && d_rd_prev)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h required 0", all_out);
        end
    endtask

    task automatic test_bias_load();
        logic       exp_b;
        logic [1:0] exp_a;
        seq_ready = 1'b1;
        ce_delay  = 3;
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_cycle0: busy=%b required 0", busy);
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            exp_b = (k <= 4);
            exp_a = exp_b ? 2'(k - 1) : 2'd0;
            n_checks++;
            if (b_rd !== exp_b || b_addr !== exp_a || c1_b_en !== (k >= 2 && k <= 5) ||
                busy !== 1'b1 || w_rd !== (k == 6)) begin
                n_fail++;
                $display("FAIL bias_cycle%0d: b_rd=%b b_addr=%0d c1_b_en=%b busy=%b w_rd=%b required %b %0d %b 1 %b",
                         k, b_rd, b_addr, c1_b_en, busy, w_rd, exp_b, exp_a,
                         (k >= 2 && k <= 5), (k == 6));
            end
        end
    endtask

    task automatic test_first_windows();
        int t0;
        bit ok;
        t0 = cyc;
        wait_edge(1'b1, 100, ok);
        n_checks++;
        if (!ok || cyc - t0 != 36) begin
            n_fail++;
            $display("FAIL window_period: got %0d cycles (seen=%b) required 36", cyc - t0, ok);
        end
        wait_edge(1'b0, 100, ok);
        n_checks++;
        if (!ok || err !== 1'b0) begin
            n_fail++;
            $display("FAIL win1_end: seen=%b err=%b required seen=1 err=0", ok, err);
        end
    endtask

    task automatic test_stray_conv_end();
        bit ok;
        wait_edge(1'b1, 100, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stray_win_start: timeout waiting for window 2");
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_pre_err: err=%b required 0", err);
        end
        ce_stray = 1'b1;
        @(negedge clk);
        ce_stray = 1'b0;
        n_checks++;
        if (err !== 1'b1 || d_rd !== 1'b1 || w_addr !== 5'd11) begin
            n_fail++;
            $display("FAIL stray_err: err=%b d_rd=%b w_addr=%0d required 1 1 11", err, d_rd, w_addr);
        end
        wait_edge(1'b0, 100, ok);
        n_checks++;
        if (!ok || err !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_sticky: seen=%b err=%b required 1 1", ok, err);
        end
    endtask

    task automatic test_reset_mid_window();
        bit ok;
        wait_edge(1'b1, 100, ok);
        repeat (17) @(negedge clk);
        n_checks++;
        if (!ok || w_addr !== 5'd17) begin
            n_fail++;
            $display("FAIL rst_setup: seen=%b w_addr=%0d required 1 17", ok, w_addr);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got %h required 0", all_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_rd !== 1'b1 || b_addr !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_restart: b_rd=%b b_addr=%0d busy=%b required 1 0 1", b_rd, b_addr, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_missing_conv_end();
        bit ok;
        ce_delay    = 1;
        ce_withhold = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_edge(1'b0, 100, ok);
        n_checks++;
        if (!ok || err !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_drain_entry: seen=%b err=%b required 1 0", ok, err);
        end
        for (int i = 2; i <= 64; i++) begin
            @(negedge clk);
            n_checks++;
            if (d_rd !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL miss_drain%0d: d_rd=%b err=%b busy=%b required 0 0 1", i, d_rd, err, busy);
            end
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || d_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_timeout: err=%b d_rd=%b required 1 0", err, d_rd);
        end
        @(posedge clk); #1;
        ce_withhold = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_rd !== 1'b1 || win_idx !== 6'd1) begin
            n_fail++;
            $display("FAIL miss_next_win: d_rd=%b win_idx=%0d required 1 1", d_rd, win_idx);
        end
    endtask

    task automatic test_full_layer();
        int n_win, n_sd, hold;
        logic [8:0] last_d;
        bit done;
        n_win  = 2;
        n_sd   = 0;
        hold   = 0;
        last_d = '0;
        done   = 1'b0;
        for (int c = 0; c < 95000 && !done; c++) begin
            @(negedge clk);
            if (d_rd && !d_rd_prev) n_win++;
            if (d_rd) last_d = d_addr;
            if (n_win == 61 && n_sd == 0 && seq_ready) seq_ready = 1'b0;
            if (seq_done) n_sd++;
            if (!seq_ready && n_sd == 1) begin
                n_checks++;
                if (b_rd !== 1'b0 || w_rd !== 1'b0 || d_rd !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wait_seq_hold: b_rd=%b w_rd=%b d_rd=%b busy=%b required 0 0 0 1",
                             b_rd, w_rd, d_rd, busy);
                end
                hold++;
                if (hold == 5) seq_ready = 1'b1;
            end
            if (layer_done) begin
                done = 1'b1;
                n_checks++;
                if (seq_done !== 1'b1 || n_sd != 42) begin
                    n_fail++;
                    $display("FAIL layer_done: seq_done=%b seq_done_count=%0d required 1 42", seq_done, n_sd);
                end
            end
        end
        n_checks++;
        if (!done || n_win != 2562 || last_d !== 9'd511) begin
            n_fail++;
            $display("FAIL full_layer: done=%b windows=%0d last_d_addr=%0d required 1 2562 511",
                     done, n_win, last_d);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || win_idx !== 6'd0 || seq_idx !== 6'd0 || layer_done !== 1'b0 ||
            seq_done !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL layer_after: busy=%b win=%0d seq=%0d ld=%b sd=%b err=%b required 0 0 0 0 0 1",
                     busy, win_idx, seq_idx, layer_done, seq_done, err);
        end
    endtask

    task automatic test_err_clear();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || b_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: err=%b b_rd=%b required 0 1", err, b_rd);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        seq_ready = 1'b0;
        ce_stray  = 1'b0;
        test_reset();
        test_bias_load();
        test_first_windows();
        test_stray_conv_end();
        test_reset_mid_window();
        test_missing_conv_end();
        test_full_layer();
        test_err_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
